// File: rtl/wave_pkg.sv
// Shared display timing constants and mood encodings for the waveform overlay.
package wave_pkg;
    localparam int H_VISIBLE = 640;
    localparam int H_TOTAL   = 800;
    localparam int V_VISIBLE = 480;
    localparam int V_TOTAL   = 525;

    typedef enum logic [1:0] {
        CALM   = 2'd0,
        NORMAL = 2'd1,
        ALERT  = 2'd2
    } mood_e;
endpackage

// File: rtl/sample_fifo.sv
// Small synchronous FIFO with a registered ready that tracks not-full.
module sample_fifo
    import wave_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int WIDTH = 9
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push_valid_i,
    output logic                       push_ready_o,
    input  logic [WIDTH-1:0]           push_data_i,
    input  logic                       pop_i,
    output logic [WIDTH-1:0]           pop_data_o,
    output logic                       full_o,
    output logic                       empty_o,
    output logic [$clog2(DEPTH+1)-1:0] count_o
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_ptr_q;
    logic [PW-1:0]    rd_ptr_q;
    logic [CW-1:0]    count_q;
    logic [CW-1:0]    count_d;
    logic             ready_q;
    logic             push;
    logic             pop;

    assign push = push_valid_i && ready_q;
    assign pop  = pop_i && (count_q != '0);

    always_comb begin
        count_d = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    // Ready is registered from the next count, so it never depends on push_valid_i.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ready_q  <= 1'b0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
            count_q <= count_d;
            ready_q <= (count_d != CW'(DEPTH));
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= push_data_i;
    end

    assign pop_data_o   = mem_q[rd_ptr_q];
    assign push_ready_o = ready_q;
    assign full_o       = (count_q == CW'(DEPTH));
    assign empty_o      = (count_q == '0);
    assign count_o      = count_q;
endmodule

// File: rtl/wave_scheduler.sv
// Buffers trace samples into a circular column memory and renders them as a
// connected waveform, one column per visible pixel.
module wave_scheduler
    import wave_pkg::*;
#(
    parameter int COLS       = 640,
    parameter int ROWS       = 480,
    parameter int FIFO_DEPTH = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       sample_valid,
    input  logic [8:0] sample_data,
    output logic       sample_ready,
    input  logic [9:0] x,
    input  logic [9:0] y,
    input  logic [1:0] mood_req,
    output logic [1:0] mood,
    output logic       draw_wave
);
    localparam int AW  = $clog2(COLS);
    localparam int CW  = $clog2(COLS + 1);
    localparam int FCW = $clog2(FIFO_DEPTH + 1);

    localparam logic [9:0] COLS_X  = 10'(COLS);
    localparam logic [9:0] ROWS_Y  = 10'(ROWS);
    localparam logic [9:0] X_LAST  = 10'(H_TOTAL - 1);
    localparam logic [9:0] Y_LAST  = 10'(V_TOTAL - 1);
    localparam logic [8:0] ROW_MAX = 9'(ROWS - 1);

    logic [8:0]     push_data;
    logic [8:0]     fifo_data;
    logic           fifo_full;
    logic           fifo_empty;
    logic [FCW-1:0] fifo_count;

    logic [9:0]     nx;
    logic [9:0]     ny;
    logic           blank;
    logic           rd_en;
    logic           drain;
    logic           frame_latch;
    logic           col_live;
    logic [10:0]    rd_sum;
    logic [10:0]    rd_idx;
    logic [AW-1:0]  rd_addr;

    logic [AW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]  fill_cnt_q, fill_cnt_d;
    logic [AW-1:0]  base_q;
    logic [CW-1:0]  shown_q;
    logic [1:0]     mood_q;

    logic [8:0]     sample_mem [COLS];
    logic [8:0]     rd_data_q;
    logic [8:0]     prev_q;
    logic           prev_self_q;
    logic           col_live_q;
    logic [8:0]     prev_eff;
    logic [8:0]     lo;
    logic [8:0]     hi;

    assign push_data = (sample_data > ROW_MAX) ? ROW_MAX : sample_data;

    sample_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (9)
    ) u_fifo (
        .clk          (clk),
        .rst          (reset),
        .push_valid_i (sample_valid),
        .push_ready_o (sample_ready),
        .push_data_i  (push_data),
        .pop_i        (drain),
        .pop_data_o   (fifo_data),
        .full_o       (fifo_full),
        .empty_o      (fifo_empty),
        .count_o      (fifo_count)
    );

    always_comb begin
        nx = x + 10'd1;
        ny = y;
        if (x == X_LAST) begin
            nx = '0;
            ny = (y == Y_LAST) ? '0 : y + 10'd1;
        end
    end

    // The column-0 lookahead at x==H_TOTAL-1 falls inside horizontal blank, so
    // draining yields to it to keep the RAM single-ported.
    assign blank       = (x >= COLS_X) || (y >= ROWS_Y);
    assign rd_en       = (nx < COLS_X) && (ny < ROWS_Y);
    assign drain       = !fifo_empty && blank && !rd_en;
    assign frame_latch = (x == '0) && (y == ROWS_Y);

    assign rd_sum   = 11'(base_q) + 11'(nx);
    assign rd_idx   = (rd_sum >= 11'(COLS)) ? rd_sum - 11'(COLS) : rd_sum;
    assign rd_addr  = AW'(rd_idx);
    assign col_live = (11'(nx) + 11'(shown_q)) >= 11'(COLS);

    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        fill_cnt_d = fill_cnt_q;
        if (drain) begin
            wr_ptr_d = (wr_ptr_q == AW'(COLS - 1)) ? '0 : wr_ptr_q + AW'(1);
            if (fill_cnt_q != CW'(COLS)) fill_cnt_d = fill_cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q   <= '0;
            fill_cnt_q <= '0;
            base_q     <= '0;
            shown_q    <= '0;
            mood_q     <= NORMAL;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            fill_cnt_q <= fill_cnt_d;
            if (frame_latch) begin
                base_q  <= wr_ptr_q;
                shown_q <= fill_cnt_q;
                mood_q  <= mood_req;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (drain) begin
            sample_mem[wr_ptr_q] <= fifo_data;
        end else if (rd_en) begin
            rd_data_q <= sample_mem[rd_addr];
        end
    end

    // prev_q trails rd_data_q by one column; prev_self_q selects the current
    // sample instead at column 0 and at the first populated column.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            prev_q      <= '0;
            prev_self_q <= 1'b1;
            col_live_q  <= 1'b0;
        end else if (rd_en) begin
            prev_q      <= rd_data_q;
            prev_self_q <= (nx == '0) || !col_live_q;
            col_live_q  <= col_live;
        end
    end

    assign prev_eff = prev_self_q ? rd_data_q : prev_q;
    assign lo       = (prev_eff < rd_data_q) ? prev_eff : rd_data_q;
    assign hi       = (prev_eff < rd_data_q) ? rd_data_q : prev_eff;

    assign draw_wave = (x < COLS_X) && (y < ROWS_Y) && col_live_q &&
                       ({1'b0, lo} <= y) && (y <= {1'b0, hi});
    assign mood      = mood_q;

    a_full_blocks_push: assert property (@(posedge clk) disable iff (reset)
        fifo_full |-> !sample_ready);
    a_count_bounded: assert property (@(posedge clk) disable iff (reset)
        fifo_count <= FCW'(FIFO_DEPTH));
endmodule

// File: tb/tb_wave_scheduler.sv
// Self-checking bench for wave_scheduler: reference model plus directed vectors.
module tb_wave_scheduler;
    timeunit 1ns;
    timeprecision 1ps;

    localparam int COLS  = 640;
    localparam int ROWS  = 480;
    localparam int DEPTH = 4;

    logic       clk          = 1'b0;
    logic       reset        = 1'b0;
    logic       sample_valid = 1'b0;
    logic [8:0] sample_data  = '0;
    logic       sample_ready;
    logic [9:0] x            = '0;
    logic [9:0] y            = '0;
    logic [1:0] mood_req     = 2'd1;
    logic [1:0] mood;
    logic       draw_wave;

    wave_scheduler #(
        .COLS       (COLS),
        .ROWS       (ROWS),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .sample_valid (sample_valid),
        .sample_data  (sample_data),
        .sample_ready (sample_ready),
        .x            (x),
        .y            (y),
        .mood_req     (mood_req),
        .mood         (mood),
        .draw_wave    (draw_wave)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    int cx = 0, cy = 0, sd = 0, cm = 1;
    int fq[$];
    int mmem [COLS];
    int m_wr, m_fill, m_base, m_shown, m_mood;
    bit m_ready;

    typedef struct {
        int phase;
        int px;
        int py;
        bit exp;
    } vec_t;
    vec_t vecs[$];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d (x=%0d y=%0d t=%0t)", nm, act, exp, cx, cy, $time);
        end
    endtask

    task automatic at(input int px, input int py);
        cx = px; cy = py;
        x = 10'(px); y = 10'(py);
    endtask

    task automatic set_mood(input int m);
        cm = m;
        mood_req = 2'(m);
    endtask

    task automatic model_reset();
        fq.delete();
        m_wr = 0; m_fill = 0; m_base = 0; m_shown = 0; m_mood = 1;
        m_ready = 1'b0;
    endtask

    function automatic bit model_draw(input int c, input int row);
        int cur, prv, lo, hi, first;
        if (c >= COLS || row >= ROWS) return 1'b0;
        first = COLS - m_shown;
        if (c < first) return 1'b0;
        cur = mmem[(m_base + c) % COLS];
        prv = (c == 0 || c - 1 < first) ? cur : mmem[(m_base + c - 1) % COLS];
        lo = (prv < cur) ? prv : cur;
        hi = (prv < cur) ? cur : prv;
        return (row >= lo) && (row <= hi);
    endfunction

    // One clock: compare registered outputs, then advance the model by the spec rules.
    task automatic cycle(output bit acc);
        bit drain, latch;
        int d;
        check("sample_ready", 32'(sample_ready), 32'(m_ready));
        acc   = sample_valid && m_ready;
        drain = (fq.size() > 0) && (cx >= COLS || cy >= ROWS);
        latch = (cx == 0) && (cy == ROWS);
        @(posedge clk);
        #1;
        if (latch) begin
            m_base = m_wr; m_shown = m_fill; m_mood = cm;
        end
        if (drain) begin
            d = fq.pop_front();
            mmem[m_wr] = d;
            m_wr = (m_wr + 1) % COLS;
            if (m_fill < COLS) m_fill++;
        end
        if (acc) fq.push_back(sd > ROWS - 1 ? ROWS - 1 : sd);
        m_ready = (fq.size() < DEPTH);
        check("mood", 32'(mood), 32'(m_mood));
    endtask

    task automatic offer(input int d);
        sd = d;
        sample_data = 9'(d);
        sample_valid = 1'b1;
    endtask

    task automatic push_one(input int d);
        bit acc;
        int n;
        n = 0;
        offer(d);
        do begin
            cycle(acc);
            n++;
        end while (!acc && n < 50);
        check("push_accepted", 32'(acc), 1);
        sample_valid = 1'b0;
    endtask

    task automatic flush();
        bit a;
        sample_valid = 1'b0;
        at(700, 100);
        repeat (DEPTH + 2) cycle(a);
    endtask

    task automatic frame_latch();
        bit a;
        at(0, ROWS); cycle(a);
        at(1, ROWS); cycle(a);
    endtask

    task automatic do_reset();
        #2 reset = 1'b1;
        #1;
        check("rst_ready", 32'(sample_ready), 0);
        check("rst_draw", 32'(draw_wave), 0);
        check("rst_mood", 32'(mood), 1);
        @(posedge clk);
        @(posedge clk);
        #1 reset = 1'b0;
        model_reset();
    endtask

    task automatic probe(input int px, input int py, input bit exp);
        bit a;
        int prow;
        prow = (py == 0) ? 524 : py - 1;
        if (px == 0) begin
            at(799, prow); cycle(a);
        end else if (px == 1) begin
            at(799, prow); cycle(a);
            at(0, py); cycle(a);
        end else begin
            at(px - 2, py); cycle(a);
            at(px - 1, py); cycle(a);
        end
        at(px, py);
        #1;
        check("vec_draw", 32'(draw_wave), 32'(exp));
        check("vec_model", 32'(draw_wave), 32'(model_draw(px, py)));
        cycle(a);
    endtask

    task automatic run_table(input int p);
        foreach (vecs[i]) begin
            if (vecs[i].phase == p) probe(vecs[i].px, vecs[i].py, vecs[i].exp);
        end
    endtask

    task automatic scan_row(input int row, input int xend, output int hits);
        bit a;
        hits = 0;
        at(799, (row == 0) ? 524 : row - 1);
        cycle(a);
        for (int c = 0; c <= xend; c++) begin
            at(c, row);
            #1;
            check("draw_scan", 32'(draw_wave), 32'(model_draw(c, row)));
            if (draw_wave === 1'b1) hits++;
            cycle(a);
        end
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bit a;
        int hits, k, r;
        int s[645];
        int s6[6];

        vecs.push_back('{0, 636, 150, 1'b0});
        vecs.push_back('{0, 637, 100, 1'b1});
        vecs.push_back('{0, 637, 101, 1'b0});
        vecs.push_back('{0, 638,  99, 1'b0});
        vecs.push_back('{0, 638, 100, 1'b1});
        vecs.push_back('{0, 638, 150, 1'b1});
        vecs.push_back('{0, 638, 200, 1'b1});
        vecs.push_back('{0, 638, 201, 1'b0});
        vecs.push_back('{0, 639, 149, 1'b0});
        vecs.push_back('{0, 639, 150, 1'b1});
        vecs.push_back('{0, 639, 200, 1'b1});
        vecs.push_back('{0, 639, 201, 1'b0});
        vecs.push_back('{0,   0, 100, 1'b0});
        vecs.push_back('{0, 320, 150, 1'b0});
        vecs.push_back('{0, 700, 150, 1'b0});
        vecs.push_back('{1, 639, 479, 1'b1});
        vecs.push_back('{1, 639, 478, 1'b0});
        vecs.push_back('{1, 638, 479, 1'b0});
        vecs.push_back('{2,   0, 333, 1'b1});
        vecs.push_back('{2,   0, 332, 1'b0});
        vecs.push_back('{2,   0, 334, 1'b0});
        vecs.push_back('{2,   1, 333, 1'b1});
        vecs.push_back('{2,   1, 400, 1'b1});
        vecs.push_back('{2,   1, 401, 1'b0});
        vecs.push_back('{2,   1, 332, 1'b0});
        vecs.push_back('{2, 639,  50, 1'b1});
        vecs.push_back('{2, 320, 240, 1'b1});

        // Reset, three samples in blanking, one frame latch.
        at(638, 100);
        set_mood(1);
        do_reset();
        at(700, 100);
        push_one(100);
        push_one(200);
        push_one(150);
        flush();
        frame_latch();
        run_table(0);
        scan_row(150, COLS - 1, hits);
        check("hits_row150", 32'(hits), 2);

        // Out-of-range sample is clamped to the bottom row.
        do_reset();
        at(700, 100);
        push_one(511);
        flush();
        frame_latch();
        run_table(1);

        // Mood follows the request only at the frame latch.
        set_mood(0);
        frame_latch();
        check("mood_calm", 32'(mood), 0);
        at(300, 200); set_mood(2); cycle(a);
        check("mood_hold_300_200", 32'(mood), 0);
        at(639, 479); cycle(a);
        check("mood_hold_639_479", 32'(mood), 0);
        at(799, 479); cycle(a);
        check("mood_hold_799_479", 32'(mood), 0);
        at(0, 480); cycle(a);
        check("mood_alert", 32'(mood), 2);
        set_mood(3);
        frame_latch();
        check("mood_passthru_3", 32'(mood), 3);

        // Back-to-back pushes in the visible region fill the FIFO.
        do_reset();
        s6 = '{50, 60, 70, 80, 90, 100};
        at(100, 100);
        k = 0;
        for (int n = 0; n < 20 && k < 4; n++) begin
            offer(s6[k]);
            cycle(a);
            if (a) k++;
        end
        check("push4_accepted", 32'(k), 4);
        offer(s6[4]);
        for (int n = 0; n < 3; n++) begin
            at(300 + 100 * n, 100);
            cycle(a);
            check("full_hold", 32'(sample_ready), 0);
        end
        at(639, 100); cycle(a);
        check("full_at_639", 32'(sample_ready), 0);
        for (int n = 0; n < 20 && k < 6; n++) begin
            offer(s6[k]);
            at(640 + n, 100);
            cycle(a);
            if (a) k++;
            if (n == 0) check("ready_after_640", 32'(sample_ready), 1);
        end
        check("push6_accepted", 32'(k), 6);
        flush();
        frame_latch();
        scan_row(75, COLS - 1, hits);

        // 645 random samples wrap the write pointer and saturate the fill count.
        do_reset();
        for (int i = 0; i < 645; i++) s[i] = int'($urandom_range(0, 511));
        s[4] = 10; s[5] = 333; s[6] = 400; s[325] = 240; s[326] = 240; s[644] = 50;
        at(700, 100);
        for (int i = 0; i < 645; i++) begin
            sample_valid = 1'b0;
            repeat ($urandom_range(0, 2)) cycle(a);
            push_one(s[i]);
        end
        flush();
        frame_latch();
        run_table(2);
        for (int i = 0; i < 2; i++) begin
            r = int'($urandom_range(0, ROWS - 1));
            scan_row(r, COLS - 1, hits);
        end

        // Reset mid-frame with a full FIFO blanks the trace for the next frame.
        scan_row(240, 320, hits);
        for (int i = 0; i < DEPTH; i++) push_one(100 + i);
        check("fifo_full_ready", 32'(sample_ready), 0);
        #1;
        check("pre_reset_draw", 32'(draw_wave), 1);
        do_reset();
        frame_latch();
        scan_row(240, COLS - 1, hits);
        check("no_trace_after_reset", 32'(hits), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
